// File: rtl/gcd_pkg.sv
// Shared types and defaults for the subtractive-Euclid GCD engine.
package gcd_pkg;

    localparam int unsigned GCD_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } gcd_state_t;

endpackage

// File: rtl/gcd_step.sv
// Combinational compare/subtract unit: one subtractive Euclid step on (a, b).
module gcd_step
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] next_a,
    output logic [WIDTH-1:0] next_b,
    output logic             finished,
    output logic [WIDTH-1:0] result
);

    // Zero and equal operands end the iteration; the surviving operand is the answer.
    always_comb begin
        finished = (a == '0) || (b == '0) || (a == b);
        result   = (a == '0) ? b : a;
        next_a   = a;
        next_b   = b;
        if (a > b) begin
            next_a = a - b;
        end else begin
            next_b = b - a;
        end
    end

endmodule

// File: rtl/gcd_calculator.sv
// Free-running GCD engine: restarts whenever x/y change, one subtract step per clock,
// result registered on gcd and updated only when a computation terminates.
module gcd_calculator
    import gcd_pkg::*;
#(
    parameter int unsigned WIDTH = GCD_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] gcd
);

    gcd_state_t       state;
    gcd_state_t       state_nxt;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] x_q;
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] a_nxt;
    logic [WIDTH-1:0] b_nxt;
    logic [WIDTH-1:0] x_q_nxt;
    logic [WIDTH-1:0] y_q_nxt;
    logic [WIDTH-1:0] gcd_nxt;

    logic [WIDTH-1:0] step_a_c;
    logic [WIDTH-1:0] step_b_c;
    logic             step_finished_c;
    logic [WIDTH-1:0] step_result_c;
    logic             operands_changed_c;

    gcd_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a        (a),
        .b        (b),
        .next_a   (step_a_c),
        .next_b   (step_b_c),
        .finished (step_finished_c),
        .result   (step_result_c)
    );

    assign operands_changed_c = (x != x_q) || (y != y_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
            a     <= '0;
            b     <= '0;
            x_q   <= '0;
            y_q   <= '0;
            gcd   <= '0;
        end else begin
            state <= state_nxt;
            a     <= a_nxt;
            b     <= b_nxt;
            x_q   <= x_q_nxt;
            y_q   <= y_q_nxt;
            gcd   <= gcd_nxt;
        end
    end

    // Next-state and datapath updates; an operand change always wins over termination.
    always_comb begin
        state_nxt = state;
        a_nxt     = a;
        b_nxt     = b;
        x_q_nxt   = x_q;
        y_q_nxt   = y_q;
        gcd_nxt   = gcd;
        unique case (state)
            LOAD: begin
                a_nxt     = x;
                b_nxt     = y;
                x_q_nxt   = x;
                y_q_nxt   = y;
                state_nxt = CALC;
            end
            CALC: begin
                if (operands_changed_c) begin
                    state_nxt = LOAD;
                end else if (step_finished_c) begin
                    gcd_nxt   = step_result_c;
                    state_nxt = DONE;
                end else begin
                    a_nxt = step_a_c;
                    b_nxt = step_b_c;
                end
            end
            DONE: begin
                if (operands_changed_c) begin
                    state_nxt = LOAD;
                end
            end
            default: begin
                state_nxt = LOAD;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_calculator.sv
// Self-checking bench for gcd_calculator against a modulo-Euclid reference model.
module tb_gcd_calculator;

    logic        clk;
    logic        reset;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] gcd;

    int unsigned tests_run;
    int unsigned tests_failed;
    logic [31:0] cur_gcd;

    gcd_calculator #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y),
        .gcd   (gcd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_gcd(input logic [31:0] p, input logic [31:0] q);
        logic [31:0] t;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Apply a pair, wait (bounded) for the model result, and require gcd to show only old or new value.
    task automatic run_pair(input logic [31:0] nx, input logic [31:0] ny,
                            input int bound, input string name);
        logic [31:0] expv;
        logic [31:0] oldv;
        logic [31:0] badv;
        int cyc;
        bit hit;
        bit bad;
        oldv = cur_gcd;
        expv = ref_gcd(nx, ny);
        x = nx;
        y = ny;
        hit = 0;
        bad = 0;
        badv = '0;
        cyc = 0;
        while (!hit && cyc < bound) begin
            step();
            cyc++;
            if (gcd === expv) hit = 1;
            else if (gcd !== oldv) begin
                bad = 1;
                badv = gcd;
            end
        end
        tests_run++;
        if (!hit) begin
            tests_failed++;
            $display("FAIL %s result: got %0d, expected %0d within %0d cycles", name, gcd, expv, bound);
        end
        tests_run++;
        if (bad) begin
            tests_failed++;
            $display("FAIL %s glitch: gcd showed %0d, allowed only %0d or %0d", name, badv, oldv, expv);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (gcd !== expv) begin
                tests_failed++;
                $display("FAIL %s hold: got %0d, expected %0d", name, gcd, expv);
            end
        end
        cur_gcd = expv;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        x = 32'd40;
        y = 32'd20;
        step();
        step();
        tests_run++;
        if (gcd !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_value: got %0d, expected 0", gcd);
        end
        reset = 1'b1;
        cur_gcd = 32'd0;
        run_pair(32'd40, 32'd20, 4, "reset_40_20");
    endtask

    task automatic test_change_in_done();
        run_pair(32'd10, 32'd60, 10, "done_10_60");
    endtask

    task automatic test_zero_cases();
        run_pair(32'd0,  32'd25, 3, "zero_0_25");
        run_pair(32'd25, 32'd0,  3, "zero_25_0");
        run_pair(32'd0,  32'd0,  3, "zero_0_0");
        run_pair(32'd17, 32'd17, 3, "equal_17");
    endtask

    task automatic test_coprime_large();
        run_pair(32'd1071, 32'd462, 30, "pair_1071_462");
        run_pair(32'd13,   32'd8,   15, "coprime_13_8");
        run_pair(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, "max_equal");
    endtask

    task automatic test_mid_change();
        x = 32'd1000;
        y = 32'd1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if (gcd !== cur_gcd) begin
                tests_failed++;
                $display("FAIL mid_change_hold: got %0d, expected %0d", gcd, cur_gcd);
            end
        end
        run_pair(32'd48, 32'd18, 20, "mid_change_48_18");
    endtask

    task automatic test_async_reset();
        x = 32'd1071;
        y = 32'd462;
        step();
        step();
        step();
        step();
        #2;
        reset = 1'b0;
        #1;
        tests_run++;
        if (gcd !== 32'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %0d, expected 0 before next edge", gcd);
        end
        @(negedge clk);
        reset = 1'b1;
        cur_gcd = 32'd0;
        run_pair(32'd1071, 32'd462, 30, "after_reset_1071_462");
    endtask

    task automatic test_random();
        logic [31:0] rx;
        logic [31:0] ry;
        int mx;
        for (int n = 0; n < 20; n++) begin
            rx = 32'($urandom_range(0, 200));
            ry = 32'($urandom_range(0, 200));
            if (n % 7 == 3) rx = 32'd0;
            mx = (rx > ry) ? int'(rx) : int'(ry);
            run_pair(rx, ry, mx + 8, "random");
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        cur_gcd = '0;
        reset = 1'b0;
        x = '0;
        y = '0;
        test_reset();
        test_change_in_done();
        test_zero_cases();
        test_coprime_large();
        test_mid_change();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
